// File: rtl/operand_if.sv
// Handshake and data bundle for the operand stage. The DUT takes the slave view,
// and whatever feeds it and consumes its outputs takes the master view.
interface operand_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [4:0]      i_rs1;
  logic [4:0]      i_rs2;
  logic [4:0]      i_rd;
  logic [XLEN-1:0] i_imm;
  logic            i_use_imm;
  logic [3:0]      i_alu_ctrl;
  logic            i_flush;
  logic            i_we;
  logic [4:0]      i_waddr;
  logic [XLEN-1:0] i_wdata;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_a;
  logic [XLEN-1:0] o_b;
  logic [XLEN-1:0] o_rs2_data;
  logic [4:0]      o_rd;
  logic [3:0]      o_alu_ctrl;

  modport slave (
    input  i_valid, i_rs1, i_rs2, i_rd, i_imm, i_use_imm, i_alu_ctrl, i_flush,
    input  i_we, i_waddr, i_wdata, i_ready,
    output o_ready, o_valid, o_a, o_b, o_rs2_data, o_rd, o_alu_ctrl
  );

  modport master (
    output i_valid, i_rs1, i_rs2, i_rd, i_imm, i_use_imm, i_alu_ctrl, i_flush,
    output i_we, i_waddr, i_wdata, i_ready,
    input  o_ready, o_valid, o_a, o_b, o_rs2_data, o_rd, o_alu_ctrl
  );
endinterface

// File: rtl/operand_stage.sv
// Operand fetch stage: register file with write-through bypass feeding a single
// output register slice with valid/ready handshake and flush.
module operand_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic      i_clk,
  input  logic      i_rst,
  operand_if.slave  bus
);

  localparam int AW = 5;

  logic [XLEN-1:0] r_regs [NREG];

  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [XLEN-1:0] w_opb;
  logic            w_ready;
  logic            w_accept;

  logic            r_vld_p1;
  logic [XLEN-1:0] r_a_p1;
  logic [XLEN-1:0] r_b_p1;
  logic [XLEN-1:0] r_rs2_p1;
  logic [AW-1:0]   r_rd_p1;
  logic [3:0]      r_alu_p1;

  // x0 reads as zero; a same-cycle writeback to a nonzero source wins over the array.
  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   addr,
    input logic            we,
    input logic [AW-1:0]   waddr,
    input logic [XLEN-1:0] wdata,
    input logic [XLEN-1:0] stored
  );
    if (addr == '0)
      return '0;
    if (we && (waddr == addr))
      return wdata;
    return stored;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else if (bus.i_we && (bus.i_waddr != '0)) begin
      r_regs[bus.i_waddr] <= bus.i_wdata;
    end
  end

  always_comb begin
    w_rs1_data = read_port(bus.i_rs1, bus.i_we, bus.i_waddr, bus.i_wdata, r_regs[bus.i_rs1]);
    w_rs2_data = read_port(bus.i_rs2, bus.i_we, bus.i_waddr, bus.i_wdata, r_regs[bus.i_rs2]);
    w_opb      = bus.i_use_imm ? bus.i_imm : w_rs2_data;
    w_ready    = !r_vld_p1 || bus.i_ready;
    w_accept   = bus.i_valid && w_ready && !bus.i_flush;
  end

  // ---- stage p0 -> p1: output register slice ----
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_vld_p1 <= 1'b0;
    else if (bus.i_flush)
      r_vld_p1 <= 1'b0;
    else if (w_ready)
      r_vld_p1 <= w_accept;
  end

  // Data only moves on accept, so a stalled instruction never sees later writebacks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_p1   <= '0;
      r_b_p1   <= '0;
      r_rs2_p1 <= '0;
      r_rd_p1  <= '0;
      r_alu_p1 <= '0;
    end else if (w_accept) begin
      r_a_p1   <= w_rs1_data;
      r_b_p1   <= w_opb;
      r_rs2_p1 <= w_rs2_data;
      r_rd_p1  <= bus.i_rd;
      r_alu_p1 <= bus.i_alu_ctrl;
    end
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_valid    = r_vld_p1;
  assign bus.o_a        = r_a_p1;
  assign bus.o_b        = r_b_p1;
  assign bus.o_rs2_data = r_rs2_p1;
  assign bus.o_rd       = r_rd_p1;
  assign bus.o_alu_ctrl = r_alu_p1;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: one table row per clock cycle, then a
// hand-written reset-during-stall sequence.
module tb_operand_stage;

  logic clk = 1'b0;
  logic rst;

  operand_if #(.XLEN(32)) bus ();

  operand_stage #(.XLEN(32), .NREG(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] we, waddr, wdata;
    logic [31:0] valid, rs1, rs2, rd, imm, use_imm, alu, flush, ready;
    logic [31:0] e_rdy, e_vld, e_a, e_b, e_r2, e_rd, e_alu;
  } vec_t;

  vec_t tv [18];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_we       = v.we[0];
    bus.i_waddr    = v.waddr[4:0];
    bus.i_wdata    = v.wdata;
    bus.i_valid    = v.valid[0];
    bus.i_rs1      = v.rs1[4:0];
    bus.i_rs2      = v.rs2[4:0];
    bus.i_rd       = v.rd[4:0];
    bus.i_imm      = v.imm;
    bus.i_use_imm  = v.use_imm[0];
    bus.i_alu_ctrl = v.alu[3:0];
    bus.i_flush    = v.flush[0];
    bus.i_ready    = v.ready[0];
  endtask

  task automatic chk_outs(input int idx, input logic [31:0] vld, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r2,
                          input logic [31:0] rd, input logic [31:0] alu);
    chk("o_valid",    idx, 32'(bus.o_valid), vld);
    chk("o_a",        idx, bus.o_a, a);
    chk("o_b",        idx, bus.o_b, b);
    chk("o_rs2_data", idx, bus.o_rs2_data, r2);
    chk("o_rd",       idx, 32'(bus.o_rd), rd);
    chk("o_alu_ctrl", idx, 32'(bus.o_alu_ctrl), alu);
  endtask

  initial begin
    //        we wa wdata         vld rs1 rs2 rd imm           ui alu fl rdy | rdy vld a             b             r2            rd alu
    tv[0]  = '{1, 5, 32'h10,       0, 0, 0, 0,  0,            0, 0, 0, 1,   1, 0, 0,            0,            0,            0, 0};
    tv[1]  = '{0, 0, 0,            1, 5, 0, 1,  32'hFFFFFFFC, 1, 2, 0, 1,   1, 1, 32'h10,       32'hFFFFFFFC, 0,            1, 2};
    tv[2]  = '{1, 0, 32'h1234,     1, 0, 0, 2,  0,            0, 3, 0, 1,   1, 1, 0,            0,            0,            2, 3};
    tv[3]  = '{0, 0, 0,            1, 0, 5, 3,  0,            0, 4, 0, 1,   1, 1, 0,            32'h10,       32'h10,       3, 4};
    tv[4]  = '{1, 7, 32'hDEAD0001, 1, 7, 7, 7,  0,            0, 1, 0, 1,   1, 1, 32'hDEAD0001, 32'hDEAD0001, 32'hDEAD0001, 7, 1};
    tv[5]  = '{0, 0, 0,            1, 7, 5, 4,  32'h55,       1, 5, 0, 1,   1, 1, 32'hDEAD0001, 32'h55,       32'h10,       4, 5};
    tv[6]  = '{1, 5, 32'h99,       1, 5, 7, 9,  0,            0, 6, 0, 0,   0, 1, 32'hDEAD0001, 32'h55,       32'h10,       4, 5};
    tv[7]  = '{0, 0, 0,            1, 5, 7, 9,  0,            0, 6, 0, 0,   0, 1, 32'hDEAD0001, 32'h55,       32'h10,       4, 5};
    tv[8]  = '{0, 0, 0,            1, 5, 7, 9,  0,            0, 6, 0, 0,   0, 1, 32'hDEAD0001, 32'h55,       32'h10,       4, 5};
    tv[9]  = '{0, 0, 0,            1, 5, 7, 9,  0,            0, 6, 0, 1,   1, 1, 32'h99,       32'hDEAD0001, 32'hDEAD0001, 9, 6};
    tv[10] = '{0, 0, 0,            0, 0, 0, 0,  0,            0, 0, 0, 1,   1, 0, 32'h99,       32'hDEAD0001, 32'hDEAD0001, 9, 6};
    tv[11] = '{0, 0, 0,            0, 0, 0, 0,  0,            0, 0, 0, 0,   1, 0, 32'h99,       32'hDEAD0001, 32'hDEAD0001, 9, 6};
    tv[12] = '{0, 0, 0,            1, 7, 0, 10, 32'h1,        1, 7, 0, 0,   1, 1, 32'hDEAD0001, 32'h1,        0,            10, 7};
    tv[13] = '{1, 12, 32'hCAFE,    1, 12, 0, 11, 0,           0, 8, 1, 1,   1, 0, 32'hDEAD0001, 32'h1,        0,            10, 7};
    tv[14] = '{0, 0, 0,            1, 12, 0, 11, 0,           0, 8, 0, 1,   1, 1, 32'hCAFE,     0,            0,            11, 8};
    tv[15] = '{0, 0, 0,            0, 0, 0, 0,  0,            0, 0, 1, 0,   0, 0, 32'hCAFE,     0,            0,            11, 8};
    tv[16] = '{1, 3, 32'hAA,       1, 3, 0, 3,  0,            0, 9, 0, 1,   1, 1, 32'hAA,       0,            0,            3, 9};
    tv[17] = '{0, 0, 0,            1, 3, 0, 3,  0,            0, 9, 0, 0,   0, 1, 32'hAA,       0,            0,            3, 9};

    rst = 1'b1;
    drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    @(negedge clk);
    chk_outs(-1, 0, 0, 0, 0, 0, 0);
    chk("o_ready_rst", -1, 32'(bus.o_ready), 1);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tv[i]);
      #1;
      chk("o_ready", i, 32'(bus.o_ready), tv[i].e_rdy);
      @(negedge clk);
      chk_outs(i, tv[i].e_vld, tv[i].e_a, tv[i].e_b, tv[i].e_r2, tv[i].e_rd, tv[i].e_alu);
    end

    // Reset while stalled, with a writeback that must be ignored.
    rst = 1'b1;
    drive('{1, 4, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    chk_outs(100, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #1;
    chk("o_ready_post_rst", 101, 32'(bus.o_ready), 1);
    drive('{0, 0, 0, 1, 3, 4, 5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    chk_outs(102, 1, 0, 0, 0, 5, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
